// File: rtl/rb_pkg.sv
// Shared constants and grant encoding for the register-bank arbiter.
package rb_pkg;

    localparam int AW       = 4;
    localparam int DW       = 32;
    localparam int NUM_REGS = 16;
    localparam int REG_PC   = 15;

    typedef enum logic [1:0] {
        G_IDLE,
        G_WRITE,
        G_READ
    } grant_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first pending requester strictly after
// the last granted one, in circular order.
module rr_pick #(
    parameter int NREQ = 3,
    parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] pend,
    input  logic [PW-1:0]   last,
    output logic            valid,
    output logic [PW-1:0]   idx
);

    int cand;

    always_comb begin
        valid = 1'b0;
        idx   = '0;
        cand  = 0;
        // Offset 1 first so the last winner is considered only after everyone else.
        for (int k = 1; k <= NREQ; k++) begin
            cand = (int'(last) + k) % NREQ;
            if (!valid && pend[cand]) begin
                valid = 1'b1;
                idx   = PW'(cand);
            end
        end
    end

endmodule

// File: rtl/rb_arbiter.sv
// 16x32 register bank shared by NREQ toggle-handshake readers and one writer;
// one access per clock, write priority bounded by a streak limit.
module rb_arbiter
    import rb_pkg::*;
#(
    parameter int NREQ        = 3,
    parameter int AW          = rb_pkg::AW,
    parameter int DW          = rb_pkg::DW,
    parameter int WSTREAK_MAX = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NREQ-1:0]      rd_trigger,
    input  logic [NREQ*AW-1:0]   rd_addr,
    output logic [NREQ*DW-1:0]   rd_data,
    output logic [NREQ-1:0]      rd_ready,
    input  logic                 wr_trigger,
    input  logic [AW-1:0]        wr_addr,
    input  logic [DW-1:0]        wr_data,
    output logic                 wr_ready,
    output logic [DW-1:0]        pc_out
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [DW-1:0]   regs [NUM_REGS];
    logic [NREQ-1:0] rd_phase;
    logic [NREQ-1:0] rd_pend;
    logic [NREQ-1:0] rd_gnt;
    logic            wr_phase;
    logic            wr_pend;
    logic            any_rd;
    logic [PW-1:0]   rr_ptr;
    logic [PW-1:0]   pick_idx;
    logic            pick_valid;
    logic [1:0]      wstreak;
    logic [AW-1:0]   sel_addr;
    grant_t          grant;

    function automatic logic [1:0] sat_inc(input logic [1:0] v);
        return (v == 2'b11) ? v : v + 2'd1;
    endfunction

    assign rd_pend  = rd_trigger ^ rd_phase;
    assign wr_pend  = wr_trigger ^ wr_phase;
    assign any_rd   = |rd_pend;
    assign rd_ready = ~rd_pend;
    assign wr_ready = ~wr_pend;
    assign pc_out   = regs[REG_PC];

    rr_pick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_pick (
        .pend  (rd_pend),
        .last  (rr_ptr),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    always_comb begin
        sel_addr = rd_addr[int'(pick_idx)*AW +: AW];
    end

    // Write wins unless it has already held off a waiting reader WSTREAK_MAX times.
    always_comb begin
        grant = G_IDLE;
        if (wr_pend && (!any_rd || int'(wstreak) < WSTREAK_MAX)) begin
            grant = G_WRITE;
        end else if (pick_valid) begin
            grant = G_READ;
        end
    end

    always_comb begin
        rd_gnt = '0;
        if (grant == G_READ) begin
            rd_gnt[pick_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                regs[r] <= '0;
            end
            rd_phase <= '0;
            wr_phase <= 1'b0;
            rd_data  <= '0;
            rr_ptr   <= '0;
            wstreak  <= '0;
        end else begin
            case (grant)
                G_WRITE: begin
                    regs[wr_addr] <= wr_data;
                    wr_phase      <= wr_trigger;
                    wstreak       <= any_rd ? sat_inc(wstreak) : 2'd0;
                end
                G_READ: begin
                    rd_data[int'(pick_idx)*DW +: DW] <= regs[sel_addr];
                    rd_phase[pick_idx]               <= rd_trigger[pick_idx];
                    rr_ptr                           <= pick_idx;
                    wstreak                          <= 2'd0;
                end
                default: begin
                end
            endcase
        end
    end

    // A second toggle before service cancels the first and the request is lost.
    for (genvar g = 0; g < NREQ; g++) begin : g_rd_retoggle
        a_rd_retoggle: assert property (@(posedge clk) disable iff (!reset_n)
            (rd_pend[g] && !rd_gnt[g]) |=> $stable(rd_trigger[g]));
    end

    a_wr_retoggle: assert property (@(posedge clk) disable iff (!reset_n)
        (wr_pend && grant != G_WRITE) |=> $stable(wr_trigger));

endmodule
